// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional feature macro: IFQ_BYPASS_EN (see instr_fetch_queue.sv).
package ifq_pkg;

    // One queued instruction: the PC it was fetched from and the raw word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] icode;
    } ifq_entry_t;

    // Shown to dispatch when the queue is empty; decodes to no queue enable.
    localparam logic [31:0] IFQ_EMPTY_ICODE = 32'h0;

    // Sequential fetch advances one 32-bit word at a time.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifq_ram.sv
// Entry storage for the instruction fetch queue: one synchronous write port
// and one asynchronous read port. Contents are not reset; the top level only
// presents an entry when its pointers say it is valid.
module ifq_ram
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  ifq_entry_t    wr_data,
    input  logic [AW-1:0] rd_addr,
    output ifq_entry_t    rd_data
);

    ifq_entry_t mem [DEPTH];

    // Capture a fetched entry into its slot on the rising edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-side instruction queue: owns the fetch PC, issues one outstanding
// request at a time to the instruction cache, buffers {pc, icode} pairs in a
// circular FIFO and hands the head entry to dispatch. A flush redirects the
// fetch PC, empties the queue and drops any word still in flight.
// Optional feature macro: IFQ_BYPASS_EN -- when defined, a word arriving at an
// empty queue is shown to dispatch in the same cycle it is acknowledged.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] ifq_icode,
    output logic [31:0] ifq_pc,
    output logic        ifq_empty,
    input  logic        dispatch_rd_en,
    input  logic        flush_en,
    input  logic [31:0] flush_pc
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state;
    logic             discard;
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic       full;
    logic       empty;
    logic       ack_in_wait;
    logic       accept;
    logic       bypass_take;
    logic       push;
    logic       pop;
    ifq_entry_t wr_entry;
    ifq_entry_t head_entry;

    // The pointer MSB is a wrap bit, so equal indices mean either full or empty.
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty = (wr_ptr == rd_ptr);

    // An ack only means something while a request is outstanding; a flush or a
    // pending discard turns it into a dropped word.
    assign ack_in_wait = (state == ST_WAIT) && fetch_ack;
    assign accept      = ack_in_wait && !discard && !flush_en;

`ifdef IFQ_BYPASS_EN
    assign bypass_take = empty && accept && dispatch_rd_en;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = accept && !bypass_take;
    assign pop  = dispatch_rd_en && !empty && !flush_en;

    // While a request is outstanding its slot is already accounted for, and
    // only IDLE can issue, so "not full" covers count + outstanding < DEPTH.
    assign fetch_req  = (state == ST_IDLE) && !flush_en && !full;
    assign fetch_addr = fetch_pc;

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.icode = fetch_data;

    ifq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (head_entry)
    );

    // Advance the FIFO pointers; a flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Track the fetch PC: redirect on flush, step past each accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= PC_RESET;
        end else if (flush_en) begin
            fetch_pc <= word_align(flush_pc);
        end else if (accept) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // Request FSM with a discard flag for a word that a flush has orphaned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            discard <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fetch_ack) begin
                        state   <= ST_IDLE;
                        discard <= 1'b0;
                    end else if (flush_en) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    discard <= 1'b0;
                end
            endcase
        end
    end

    // Present the head entry, or the zero pattern when nothing is valid.
    always_comb begin
        ifq_empty = empty;
        ifq_pc    = empty ? 32'h0 : head_entry.pc;
        ifq_icode = empty ? IFQ_EMPTY_ICODE : head_entry.icode;
`ifdef IFQ_BYPASS_EN
        if (empty && accept) begin
            ifq_empty = 1'b0;
            ifq_pc    = fetch_pc;
            ifq_icode = fetch_data;
        end
`endif
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios with literal
// expectations followed by randomized traffic compared every cycle against a
// queue-based behavioural model. Honours IFQ_BYPASS_EN if it is defined.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_RESET = 32'h0040_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] icode;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic [31:0] ifq_icode;
    logic [31:0] ifq_pc;
    logic        ifq_empty;
    logic        dispatch_rd_en;
    logic        flush_en;
    logic [31:0] flush_pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nreq   = 0;

    // Behavioural model state
    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_wait;
    bit          m_disc;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .PC_RESET (PC_RESET)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_ack      (fetch_ack),
        .fetch_data     (fetch_data),
        .ifq_icode      (ifq_icode),
        .ifq_pc         (ifq_pc),
        .ifq_empty      (ifq_empty),
        .dispatch_rd_en (dispatch_rd_en),
        .flush_en       (flush_en),
        .flush_pc       (flush_pc)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_pc   = PC_RESET;
        m_wait = 1'b0;
        m_disc = 1'b0;
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic rd,
                                 input logic fl, input logic [31:0] fpc);
        @(posedge clk);
        #1;
        fetch_ack      = ack;
        fetch_data     = data;
        dispatch_rd_en = rd;
        flush_en       = fl;
        flush_pc       = fpc;
        cyc++;
    endtask

    // Compare this cycle's outputs against the model, then advance the model
    // to what the coming clock edge should produce.
    task automatic checkOutput();
        logic        e_req;
        logic        e_empty;
        logic [31:0] e_pc;
        logic [31:0] e_icode;
        logic        byp;
        logic        acc;
        int          sz;

        sz    = q.size();
        e_req = !m_wait && !flush_en && (sz < DEPTH);
        byp   = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = (sz == 0) && m_wait && fetch_ack && !m_disc && !flush_en;
`endif
        if (sz > 0) begin
            e_empty = 1'b0; e_pc = q[0].pc; e_icode = q[0].icode;
        end else if (byp) begin
            e_empty = 1'b0; e_pc = m_pc; e_icode = fetch_data;
        end else begin
            e_empty = 1'b1; e_pc = 32'h0; e_icode = 32'h0;
        end

        @(negedge clk);
        checkBit("fetch_req", fetch_req, e_req);
        checkVal("fetch_addr", fetch_addr, m_pc);
        checkBit("ifq_empty", ifq_empty, e_empty);
        checkVal("ifq_pc", ifq_pc, e_pc);
        checkVal("ifq_icode", ifq_icode, e_icode);

        if (flush_en) begin
            q.delete();
            m_pc = flush_pc & ~32'h3;
            if (m_wait) begin
                if (fetch_ack) begin
                    m_wait = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    m_disc = 1'b1;
                end
            end
        end else begin
            acc = m_wait && fetch_ack && !m_disc;
            if (dispatch_rd_en && sz > 0) begin
                void'(q.pop_front());
            end
            if (acc) begin
                if (!(byp && dispatch_rd_en)) begin
                    q.push_back('{pc: m_pc, icode: fetch_data});
                end
                m_pc = m_pc + 32'd4;
            end
            if (m_wait && fetch_ack) begin
                m_wait = 1'b0;
                m_disc = 1'b0;
            end
            if (e_req) begin
                m_wait = 1'b1;
            end
        end
    endtask

    task automatic step(input logic ack, input logic [31:0] data, input logic rd,
                        input logic fl, input logic [31:0] fpc);
        applyStimulus(ack, data, rd, fl, fpc);
        checkOutput();
    endtask

    // Assert reset mid-cycle, check the reset view, then release it and model
    // the first post-reset cycle with idle inputs.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        fetch_ack      = 1'b0;
        fetch_data     = 32'h0;
        dispatch_rd_en = 1'b0;
        flush_en       = 1'b0;
        flush_pc       = 32'h0;
        modelReset();
        @(negedge clk);
        checkBit("rst_empty", ifq_empty, 1'b1);
        checkVal("rst_pc", ifq_pc, 32'h0);
        checkVal("rst_icode", ifq_icode, 32'h0);
        checkVal("rst_addr", fetch_addr, 32'h0040_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        checkOutput();
    endtask

    task automatic randomPhase(input int cycles, input int rd_pct);
        logic ack;
        for (int i = 0; i < cycles; i++) begin
            ack = m_wait ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            step(ack, $urandom, ($urandom_range(0, 99) < rd_pct),
                 ($urandom_range(0, 29) == 0), $urandom);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_ack      = 1'b0;
        fetch_data     = 32'h0;
        dispatch_rd_en = 1'b0;
        flush_en       = 1'b0;
        flush_pc       = 32'h0;
        modelReset();

        doReset();
        checkVal("t1_first_addr", fetch_addr, 32'h0040_0000);
        nreq = 1;

        // Fill: ack every request one cycle later, never pop.
        for (int i = 0; i < 12; i++) begin
            step(m_wait, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 32'h0);
            if (fetch_req) begin
                checkVal("t1_addr", fetch_addr, 32'h0040_0000 + 32'(4 * nreq));
                nreq++;
            end
        end
        checkVal("t1_nreq", 32'(nreq), 32'd4);
        checkBit("t1_full_req", fetch_req, 1'b0);
        checkVal("t1_head_pc", ifq_pc, 32'h0040_0000);
        checkVal("t1_head_icode", ifq_icode, 32'h1000_0000);

        // Pop one from a full queue: one new request.
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkBit("t2_req", fetch_req, 1'b1);
        checkVal("t2_addr", fetch_addr, 32'h0040_0010);
        checkVal("t2_head_pc", ifq_pc, 32'h0040_0004);

        // Flush while waiting; the late ack is dropped.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0103);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkBit("t3_empty", ifq_empty, 1'b1);
        checkBit("t3_req", fetch_req, 1'b1);
        checkVal("t3_addr", fetch_addr, 32'h0040_0100);

        // Flush, ack and pop together.
        step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkVal("t4_head_pc", ifq_pc, 32'h0040_0100);
        checkVal("t4_next_addr", fetch_addr, 32'h0040_0104);
        step(1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h0040_0200);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkBit("t4_empty", ifq_empty, 1'b1);
        checkVal("t4_icode", ifq_icode, 32'h0);
        checkVal("t4_addr", fetch_addr, 32'h0040_0200);

        // Ack to an empty queue with dispatch reading.
        step(1'b1, 32'h00A0_0093, 1'b1, 1'b0, 32'h0);
`ifdef IFQ_BYPASS_EN
        checkBit("t6_byp_empty", ifq_empty, 1'b0);
        checkVal("t6_byp_icode", ifq_icode, 32'h00A0_0093);
        checkVal("t6_byp_pc", ifq_pc, 32'h0040_0200);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkBit("t6_byp_after", ifq_empty, 1'b1);
`else
        checkBit("t6_empty_now", ifq_empty, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkBit("t6_visible", ifq_empty, 1'b0);
        checkVal("t6_icode", ifq_icode, 32'h00A0_0093);
        checkVal("t6_pc", ifq_pc, 32'h0040_0200);
`endif

        // Randomized traffic with varying dispatch pressure.
        randomPhase(600, 10);
        randomPhase(600, 50);
        doReset();
        randomPhase(600, 90);
        randomPhase(600, 35);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
